// File: rtl/pong_pkg.sv
// Shared constants, FSM state type and hit-flag payload for the pong ball controller.
package pong_pkg;

   localparam int unsigned H_VIS      = 640;
   localparam int unsigned V_VIS      = 480;
   localparam int unsigned BALL_SIZE  = 16;
   localparam int unsigned BALL_SPEED = 2;
   localparam int unsigned WIN_SCORE  = 9;
   localparam int unsigned POINT_HOLD = 60;
   localparam int unsigned SPEED_MAX  = 6;
   localparam int unsigned COORD_W    = 10;
   localparam int unsigned SCORE_W    = 4;

   localparam logic [COORD_W-1:0] SERVE_X = 10'd312;
   localparam logic [COORD_W-1:0] SERVE_Y = 10'd232;

   typedef enum logic [1:0] {
      SERVE,
      PLAY,
      POINT,
      GAMEOVER
   } state_e;

   typedef struct packed {
      logic l;
      logic r;
      logic t;
      logic b;
   } hit_t;

   // Score increment that sticks at the top of the score range.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s == '1) ? s : s + 4'd1;
   endfunction

endpackage

// File: rtl/ball_ctrl_if.sv
// Video-timing, serve and ball/score signals exchanged with the ball controller.
interface ball_ctrl_if;

   logic [pong_pkg::COORD_W-1:0] h_cnt;
   logic [pong_pkg::COORD_W-1:0] v_cnt;
   logic                         valid;
   logic                         BouncingObject;
   logic                         serve;
   logic [pong_pkg::COORD_W-1:0] ballX;
   logic [pong_pkg::COORD_W-1:0] ballY;
   logic [pong_pkg::SCORE_W-1:0] score1;
   logic [pong_pkg::SCORE_W-1:0] score2;
   logic                         game_over;

   modport master (
      output h_cnt, v_cnt, valid, BouncingObject, serve,
      input  ballX, ballY, score1, score2, game_over
   );

   modport slave (
      input  h_cnt, v_cnt, valid, BouncingObject, serve,
      output ballX, ballY, score1, score2, game_over
   );

endinterface

// File: rtl/bounce_detect.sv
// Compares the beam position against the four ball-edge probes and keeps sticky hit flags per frame.
module bounce_detect
   import pong_pkg::*;
#(
   parameter int unsigned SIZE = pong_pkg::BALL_SIZE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] h_cnt,
   input  logic [COORD_W-1:0] v_cnt,
   input  logic               valid,
   input  logic               bouncing,
   input  logic               tick,
   input  logic [COORD_W-1:0] ball_x,
   input  logic [COORD_W-1:0] ball_y,
   output hit_t               hit
);

   localparam logic [COORD_W-1:0] EDGE = COORD_W'(SIZE);
   localparam logic [COORD_W-1:0] MID  = COORD_W'(SIZE / 2);

   hit_t match_c;

   // Probe points sit mid-way along each ball edge; sums wrap at 10 bits.
   always_comb begin
      match_c = '0;
      if (valid && bouncing) begin
         match_c.l = (h_cnt == ball_x)        && (v_cnt == ball_y + MID);
         match_c.r = (h_cnt == ball_x + EDGE) && (v_cnt == ball_y + MID);
         match_c.t = (h_cnt == ball_x + MID)  && (v_cnt == ball_y);
         match_c.b = (h_cnt == ball_x + MID)  && (v_cnt == ball_y + EDGE);
      end
   end

   // The tick consumes the old flags; a match on the tick cycle itself lands in the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit <= '0;
      end else if (tick) begin
         hit <= match_c;
      end else begin
         hit <= hit_t'(hit | match_c);
      end
   end

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball controller: serve/play/point/game-over FSM, ball motion, goals and scoring.
// Optional BALL_CTRL_SPEEDUP_EN: ball speed rises by one every fourth paddle bounce.
module ball_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned BALL_SIZE  = pong_pkg::BALL_SIZE,
   parameter int unsigned BALL_SPEED = pong_pkg::BALL_SPEED,
   parameter int unsigned WIN_SCORE  = pong_pkg::WIN_SCORE,
   parameter int unsigned POINT_HOLD = pong_pkg::POINT_HOLD
) (
   input  logic        clk,
   input  logic        rst,
   ball_ctrl_if.slave  bus
);

   localparam int unsigned HOLD_W = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;

   state_e               state_q, state_d;
   logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
   logic                 dir_x_q, dir_x_d;   // 1 = right
   logic                 dir_y_q, dir_y_d;   // 1 = down
   logic [SCORE_W-1:0]   s1_q, s1_d, s2_q, s2_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic                 point_left_q, point_left_d;
   logic                 game_over_q;
   logic [COORD_W-1:0]   speed;
   logic                 tick_c, dx_c, dy_c, bounce_c, goal_l_c, goal_r_c;
   logic [SCORE_W-1:0]   s1_inc_c, s2_inc_c;
   hit_t                 hit;

`ifdef BALL_CTRL_SPEEDUP_EN
   logic [COORD_W-1:0]   speed_q, speed_d;
   logic [1:0]           bcnt_q, bcnt_d;
   assign speed = speed_q;
`else
   assign speed = COORD_W'(BALL_SPEED);
`endif

   assign tick_c = (bus.h_cnt == '0) && (bus.v_cnt == COORD_W'(V_VIS));

   bounce_detect #(.SIZE(BALL_SIZE)) u_bounce_detect (
      .clk      (clk),
      .rst      (rst),
      .h_cnt    (bus.h_cnt),
      .v_cnt    (bus.v_cnt),
      .valid    (bus.valid),
      .bouncing (bus.BouncingObject),
      .tick     (tick_c),
      .ball_x   (x_q),
      .ball_y   (y_q),
      .hit      (hit)
   );

   // Direction after this tick's bounces; opposing hits on one axis cancel out.
   always_comb begin
      dx_c = dir_x_q;
      dy_c = dir_y_q;
      if (hit.r && !hit.l)      dx_c = 1'b0;
      else if (hit.l && !hit.r) dx_c = 1'b1;
      if (hit.b && !hit.t)      dy_c = 1'b0;
      else if (hit.t && !hit.b) dy_c = 1'b1;
   end

   // Any bounce this frame suppresses a goal.
   assign bounce_c = hit.l | hit.r | hit.t | hit.b;
   assign goal_l_c = !bounce_c && !dx_c && (x_q < speed);
   assign goal_r_c = !bounce_c && dx_c &&
                     ((x_q + COORD_W'(BALL_SIZE)) > (COORD_W'(H_VIS) - speed));
   assign s1_inc_c = sat_inc(s1_q);
   assign s2_inc_c = sat_inc(s2_q);

   // Next-state and datapath updates. Serve is a one-cycle pulse, so it is acted on when it arrives.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      dir_x_d      = dir_x_q;
      dir_y_d      = dir_y_q;
      s1_d         = s1_q;
      s2_d         = s2_q;
      hold_d       = hold_q;
      point_left_d = point_left_q;
`ifdef BALL_CTRL_SPEEDUP_EN
      speed_d      = speed_q;
      bcnt_d       = bcnt_q;
`endif
      case (state_q)
         SERVE: begin
            if (bus.serve) state_d = PLAY;
         end
         PLAY: begin
            if (tick_c) begin
               dir_x_d = dx_c;
               dir_y_d = dy_c;
               if (goal_l_c) begin
                  s2_d         = s2_inc_c;
                  point_left_d = 1'b1;
                  state_d      = (s2_inc_c == SCORE_W'(WIN_SCORE)) ? GAMEOVER : POINT;
               end else if (goal_r_c) begin
                  s1_d         = s1_inc_c;
                  point_left_d = 1'b0;
                  state_d      = (s1_inc_c == SCORE_W'(WIN_SCORE)) ? GAMEOVER : POINT;
               end else begin
                  x_d = dx_c ? x_q + speed : x_q - speed;
                  y_d = dy_c ? y_q + speed : y_q - speed;
               end
`ifdef BALL_CTRL_SPEEDUP_EN
               if (hit.l || hit.r) begin
                  bcnt_d = bcnt_q + 2'd1;
                  if (bcnt_q == 2'd3 && speed_q < COORD_W'(SPEED_MAX))
                     speed_d = speed_q + 10'd1;
               end
`endif
            end
         end
         POINT: begin
            if (tick_c) begin
               if (hold_q == HOLD_W'(POINT_HOLD - 1)) begin
                  hold_d  = '0;
                  state_d = SERVE;
                  dir_x_d = !point_left_q;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
         end
         GAMEOVER: begin
            if (bus.serve) begin
               s1_d    = '0;
               s2_d    = '0;
               state_d = SERVE;
            end
         end
         default: state_d = SERVE;
      endcase
      // Every entry into SERVE re-centres the ball and restores the base speed.
      if (state_d == SERVE && state_q != SERVE) begin
         x_d = SERVE_X;
         y_d = SERVE_Y;
`ifdef BALL_CTRL_SPEEDUP_EN
         speed_d = COORD_W'(BALL_SPEED);
         bcnt_d  = '0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SERVE;
         x_q          <= SERVE_X;
         y_q          <= SERVE_Y;
         dir_x_q      <= 1'b1;
         dir_y_q      <= 1'b1;
         s1_q         <= '0;
         s2_q         <= '0;
         hold_q       <= '0;
         point_left_q <= 1'b0;
         game_over_q  <= 1'b0;
`ifdef BALL_CTRL_SPEEDUP_EN
         speed_q      <= COORD_W'(BALL_SPEED);
         bcnt_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         dir_x_q      <= dir_x_d;
         dir_y_q      <= dir_y_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         hold_q       <= hold_d;
         point_left_q <= point_left_d;
         game_over_q  <= (state_d == GAMEOVER);
`ifdef BALL_CTRL_SPEEDUP_EN
         speed_q      <= speed_d;
         bcnt_q       <= bcnt_d;
`endif
      end
   end

   assign bus.ballX     = x_q;
   assign bus.ballY     = y_q;
   assign bus.score1    = s1_q;
   assign bus.score2    = s2_q;
   assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Scoreboard bench for ball_ctrl: compressed frames, random hits/serves, behavioural game model.
module tb_ball_ctrl;
   import pong_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ball_ctrl_if bus ();

   ball_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int     x;
      int     y;
      int     s1;
      int     s2;
      bit     go;
      state_e st;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Game model: plain integers, directions as +1/-1.
   int     m_x, m_y, m_s1, m_s2, m_spd, m_bounces, m_hold, m_dx, m_dy;
   bit     m_conceded_left;
   state_e m_st;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wrap(input int v);
      return ((v % 1024) + 1024) % 1024;
   endfunction

   task automatic model_centre();
      m_x = 312; m_y = 232; m_spd = BALL_SPEED; m_bounces = 0;
   endtask

   task automatic model_reset();
      model_centre();
      m_st = SERVE; m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_hold = 0; m_conceded_left = 0;
   endtask

   task automatic model_serve();
      if (m_st == SERVE) m_st = PLAY;
      else if (m_st == GAMEOVER) begin
         m_s1 = 0; m_s2 = 0; m_st = SERVE; model_centre();
      end
   endtask

   task automatic model_tick(input bit hl, hr, ht, hb);
      bit bounced;
      bounced = hl | hr | ht | hb;
      if (m_st == PLAY) begin
         if (hr && !hl) m_dx = -1; else if (hl && !hr) m_dx = 1;
         if (hb && !ht) m_dy = -1; else if (ht && !hb) m_dy = 1;
         if (!bounced && m_dx < 0 && m_x < m_spd) begin
            m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
            m_conceded_left = 1;
            m_st = (m_s2 == WIN_SCORE) ? GAMEOVER : POINT;
         end else if (!bounced && m_dx > 0 && wrap(m_x + BALL_SIZE) > H_VIS - m_spd) begin
            m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
            m_conceded_left = 0;
            m_st = (m_s1 == WIN_SCORE) ? GAMEOVER : POINT;
         end else begin
            m_x = wrap(m_x + m_dx * m_spd);
            m_y = wrap(m_y + m_dy * m_spd);
         end
`ifdef BALL_CTRL_SPEEDUP_EN
         if (hl || hr) begin
            m_bounces++;
            if (m_bounces % 4 == 0 && m_spd < SPEED_MAX) m_spd++;
         end
`endif
      end else if (m_st == POINT) begin
         m_hold++;
         if (m_hold == POINT_HOLD) begin
            m_hold = 0; m_st = SERVE; m_dx = m_conceded_left ? -1 : 1; model_centre();
         end
      end
   endtask

   task automatic drive(input logic [9:0] h, v, input logic val, bo, srv);
      @(negedge clk);
      bus.h_cnt = h; bus.v_cnt = v; bus.valid = val; bus.BouncingObject = bo; bus.serve = srv;
   endtask

   // One compressed frame: optional probe hits and serve, then the frame tick.
   task automatic frame(input bit hl, hr, ht, hb, srv);
      logic [9:0] bx, by;
      exp_t e;
      bx = 10'(m_x);
      by = 10'(m_y);
      if (hl) drive(bx, by + 10'd8, 1'b1, 1'b1, 1'b0);
      if (hr) drive(bx + 10'd16, by + 10'd8, 1'b1, 1'b1, 1'b0);
      if (ht) drive(bx + 10'd8, by, 1'b1, 1'b1, 1'b0);
      if (hb) drive(bx + 10'd8, by + 10'd16, 1'b1, 1'b1, 1'b0);
      if (srv) begin
         drive(10'd5, 10'd5, 1'b0, 1'b0, 1'b1);
         model_serve();
      end
      drive(10'd100, 10'd100, 1'b1, 1'b0, 1'b0);
      drive(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
      model_tick(hl, hr, ht, hb);
      e.x = m_x; e.y = m_y; e.s1 = m_s1; e.s2 = m_s2; e.go = (m_st == GAMEOVER); e.st = m_st;
      sb.push_back(e);
      drive(10'd5, 10'd5, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_ballX"}, bus.ballX, 312);
      chk({tag, "_ballY"}, bus.ballY, 232);
      chk({tag, "_score1"}, bus.score1, 0);
      chk({tag, "_score2"}, bus.score2, 0);
      chk({tag, "_game_over"}, bus.game_over, 0);
      chk({tag, "_state"}, dut.state_q, SERVE);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.h_cnt = 10'd5; bus.v_cnt = 10'd5; bus.valid = 1'b0; bus.BouncingObject = 1'b0; bus.serve = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every frame tick the DUT updates; compare with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (!rst && bus.h_cnt == 10'd0 && bus.v_cnt == 10'd480) begin
            @(negedge clk);
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("sb_ballX", bus.ballX, e.x);
               chk("sb_ballY", bus.ballY, e.y);
               chk("sb_score1", bus.score1, e.s1);
               chk("sb_score2", bus.score2, e.s2);
               chk("sb_game_over", bus.game_over, e.go);
               chk("sb_state", dut.state_q, e.st);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus.h_cnt = 10'd5; bus.v_cnt = 10'd5; bus.valid = 1'b0; bus.BouncingObject = 1'b0; bus.serve = 1'b0;
      do_reset();
      check_reset_values("reset");

      // Idle frames in SERVE leave everything untouched.
      repeat (3) frame(0, 0, 0, 0, 0);
      check_reset_values("serve_idle");

      // Serve plus five ticks of free flight.
      frame(0, 0, 0, 0, 1);
      repeat (4) frame(0, 0, 0, 0, 0);
      chk("serve_move_x", bus.ballX, 322);
      chk("serve_move_y", bus.ballY, 242);

      // Right-edge hit flips X on that tick, then the ball keeps going left.
      frame(0, 1, 0, 0, 0);
      chk("flip_x_first", bus.ballX, 320);
      repeat (3) frame(0, 0, 0, 0, 0);
      chk("flip_x_after", bus.ballX, 314);

      // Run into the left goal, hold, and re-serve toward the conceding side.
      for (int i = 0; i < 400 && m_st != POINT; i++) frame(0, 0, 0, 0, 0);
      chk("left_goal_score2", bus.score2, 1);
      chk("left_goal_state", dut.state_q, POINT);
      repeat (POINT_HOLD - 1) frame(0, 0, 0, 0, 1);
      chk("hold_last_state", dut.state_q, POINT);
      frame(0, 0, 0, 0, 0);
      chk("hold_done_state", dut.state_q, SERVE);
      chk("hold_done_dirx", dut.dir_x_q, 0);
      frame(0, 0, 0, 0, 1);
      chk("reserve_left_x", bus.ballX, 310);

      // Random play against the model.
      for (int i = 0; i < 400; i++)
         frame($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 7) == 0);

      // Reset in the middle of a frame, with a pending hit that must be dropped.
      frame(0, 0, 0, 0, 1);
      frame(0, 0, 0, 0, 1);
      drive(10'(m_x) + 10'd16, 10'(m_y) + 10'd8, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check_reset_values("midframe_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      frame(0, 0, 0, 0, 1);
      chk("post_reset_x", bus.ballX, 314);

      // Right goals until the game ends, then restart.
      for (int i = 0; i < 3000 && m_st != GAMEOVER; i++) frame(0, 0, 0, 0, m_st == SERVE);
      chk("win_score1", bus.score1, 9);
      chk("win_game_over", bus.game_over, 1);
      frame(0, 0, 0, 0, 1);
      chk("restart_score1", bus.score1, 0);
      chk("restart_state", dut.state_q, SERVE);
      chk("restart_game_over", bus.game_over, 0);

`ifdef BALL_CTRL_SPEEDUP_EN
      do_reset();
      frame(0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) frame(i % 2 == 1, i % 2 == 0, 0, 0, 0);
      chk("speed_after_8", dut.speed, 4);
      for (int i = 0; i < 400 && m_st != POINT; i++) frame(0, 0, 0, 0, 0);
      repeat (POINT_HOLD) frame(0, 0, 0, 0, 0);
      frame(0, 0, 0, 0, 1);
      chk("speed_after_serve", dut.speed, 2);
`endif

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ball_ctrl.md
BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 Parameter BALL_SIZE, 16, ball edge length in pixels.
REQ-002 Parameter BALL_SPEED, 2, pixels moved per frame on each axis.
REQ-003 Parameter WIN_SCORE, 9, score that ends the game.
REQ-004 Parameter POINT_HOLD, 60, frames held after a point before the next serve.
REQ-005 clk  in  1  pixel clock shared with the VGA timing and pixel generator.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 h_cnt  in  10  current horizontal pixel count.
REQ-008 v_cnt  in  10  current vertical line count.
REQ-009 valid  in  1  visible-area flag.
REQ-010 BouncingObject  in  1  high while a border or paddle pixel is being drawn.
REQ-011 serve  in  1  one-cycle start pulse, already debounced upstream.
REQ-012 ballX  out  10  ball top-left X, registered.
REQ-013 ballY  out  10  ball top-left Y, registered.
REQ-014 score1  out  4  left player score.
REQ-015 score2  out  4  right player score.
REQ-016 game_over  out  1  high in the GAMEOVER state.

Function
REQ-017 Frame tick: a one-cycle internal pulse when h_cnt==0 and v_cnt==480; every position and state update happens only on this tick.
REQ-018 Probes are sampled only when valid && BouncingObject.
  - Left probe: (ballX, ballY+8).
  - Right probe: (ballX+16, ballY+8).
  - Top probe: (ballX+8, ballY).
  - Bottom probe: (ballX+8, ballY+16).
  - All sums use 10-bit unsigned arithmetic without wrap-around checks.
REQ-019 Sticky flags hitL, hitR, hitT and hitB shall set on a probe match and clear on the cycle after the frame tick that consumes them.
REQ-020 If a probe matches in the same cycle as the frame tick, that hit shall count for the next frame.
REQ-021 The FSM has four states: SERVE, PLAY, POINT and GAMEOVER.
REQ-022 SERVE: hold the ball at (312,232); on a serve pulse, go to PLAY.
REQ-023 PLAY, X direction: on the tick, set dirX=left if hitR, dirX=right if hitL; if both are set, keep dirX.
REQ-024 PLAY, Y direction: on the tick, apply the same rule to dirY using hitT and hitB.
REQ-025 PLAY, movement: after any direction change, move the ball BALL_SPEED pixels on each axis.
REQ-026 PLAY, left goal: on the tick, if dirX is left (after the update) and ballX < BALL_SPEED, add 1 to score2 and go to POINT.
REQ-027 PLAY, right goal: on the tick, if dirX is right and ballX+BALL_SIZE > 640-BALL_SPEED, add 1 to score1 and go to POINT.
REQ-028 If a goal and a bounce occur on the same tick, the bounce wins and no point is scored.
REQ-029 On a goal tick the ball shall not move.
REQ-030 POINT: count POINT_HOLD ticks, then go to SERVE.
REQ-031 On leaving POINT, set dirX toward the player who conceded the point.
REQ-032 If the incremented score equals WIN_SCORE, go to GAMEOVER instead of POINT.
REQ-033 Scores saturate at 15.
REQ-034 GAMEOVER: hold the ball and scores; a serve pulse clears both scores and goes to SERVE.
REQ-035 A serve pulse in PLAY or POINT is ignored.

Reset
REQ-036 On rst, the state shall be SERVE.
REQ-037 On rst, ballX=312, ballY=232, dirX=right, dirY=down.
REQ-038 On rst, scores, hit flags and the hold counter shall be 0, and game_over=0.
REQ-039 A reset asserted mid-frame shall take effect immediately; the first update after release happens on the next full frame tick.

Configuration
REQ-040 Macro BALL_CTRL_SPEEDUP_EN.
  - Defined: the speed register starts at BALL_SPEED, rises by 1 after every 4th paddle bounce (hitL or hitR), is capped at 6, and returns to BALL_SPEED on entering SERVE.
  - Undefined: speed stays at the constant BALL_SPEED and no bounce counter exists.

Structure
REQ-041 Package pong_pkg shall hold the constants H_VIS=640 and V_VIS=480, BALL_SIZE, WIN_SCORE, the serve position and the FSM state typedef.
REQ-042 Sub-module bounce_detect shall hold the probe comparison and the sticky hit flags; ball_ctrl shall hold the FSM, position, direction and scoring.

Verification
REQ-043 Reset, then 3 frames with no serve -> ball stays at (312,232), state SERVE, scores 0.
REQ-044 Serve pulse, then 5 frames with no BouncingObject -> ballX=322 and ballY=242.
REQ-045 Force BouncingObject at the right probe during one frame -> dirX flips to left at that frame's tick, and ballX falls by 2 on each following tick.
REQ-046 Ball moving left from ballX=1 with no hit -> score2=1, state POINT, then SERVE after 60 ticks with dirX=left.
REQ-047 score1=8, then a right goal -> score1=9 and game_over=1; a serve pulse -> scores 0 and state SERVE.
REQ-048 With BALL_CTRL_SPEEDUP_EN defined, 8 paddle bounces -> speed is 4; after the next goal and serve, speed is 2.
